// File: rtl/incdec_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : incdec_arbiter
// Description : Round-robin scheduler sharing one registered 8-bit inc/dec
//               unit among NREQ requesters, with a single backpressured
//               response channel. Optional result checker: INCDEC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module incdec_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ-1:0]      i_req_cmd,
    input  logic [8*NREQ-1:0]    i_req_data,
    input  logic [8*NREQ-1:0]    i_req_addr,
    output logic                 o_unit_rst_n,
    output logic                 o_unit_cmd,
    output logic [7:0]           o_unit_data,
    output logic [7:0]           o_unit_addr,
    input  logic [7:0]           i_unit_dout,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [7:0]           o_rsp_addr,
    output logic [7:0]           o_rsp_data,
    output logic                 o_chk_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_unit_rst_n;
    logic [IDW-1:0]     r_rr_last;
    logic [IDW-1:0]     r_id;
    logic               r_unit_cmd;
    logic [7:0]         r_unit_data;
    logic [7:0]         r_unit_addr;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [7:0]         r_rsp_addr;
    logic [7:0]         r_rsp_data;

    logic               w_gnt_found;
    logic [IDW-1:0]     w_gnt_idx;
    logic               w_accept;

    // Releases the unit one cycle after the arbiter leaves reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_unit_rst_n <= 1'b0;
        end else begin
            r_unit_rst_n <= 1'b1;
        end
    end

    // Search starts just after the last granted requester.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int w_idx;
            w_idx = (int'(r_rr_last) + k) % NREQ;
            if (!w_gnt_found && i_req_valid[w_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDW'(w_idx);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && r_unit_rst_n && w_gnt_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    o_req_ready[w_gnt_idx] = 1'b1;
                    w_state_nxt            = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_RESP;
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last   <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_unit_cmd  <= 1'b0;
            r_unit_data <= 8'h00;
            r_unit_addr <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_addr  <= 8'h00;
            r_rsp_data  <= 8'h00;
        end else begin
            if (w_accept) begin
                r_unit_cmd  <= i_req_cmd[w_gnt_idx];
                r_unit_data <= i_req_data[8*w_gnt_idx +: 8];
                r_unit_addr <= i_req_addr[8*w_gnt_idx +: 8];
                r_id        <= w_gnt_idx;
                r_rr_last   <= w_gnt_idx;
            end
            if (r_state == S_WAIT) begin
                r_rsp_data  <= i_unit_dout;
                r_rsp_addr  <= r_unit_addr;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == S_RESP) && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef INCDEC_CHECK_EN
    logic       r_chk_err;
    logic [7:0] w_chk_expect;

    assign w_chk_expect = r_unit_cmd ? (r_unit_data - 8'd1) : (r_unit_data + 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk_err <= 1'b0;
        end else if ((r_state == S_WAIT) && (i_unit_dout != w_chk_expect)) begin
            r_chk_err <= 1'b1;
        end
    end

    assign o_chk_err = r_chk_err;
`else
    assign o_chk_err = 1'b0;
`endif

    assign o_unit_rst_n = r_unit_rst_n;
    assign o_unit_cmd   = r_unit_cmd;
    assign o_unit_data  = r_unit_data;
    assign o_unit_addr  = r_unit_addr;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_addr   = r_rsp_addr;
    assign o_rsp_data   = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_incdec_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_incdec_arbiter
// Description : Directed self-checking bench for incdec_arbiter with a
//               behavioural inc/dec unit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_incdec_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_data = '0;
    logic [31:0] req_addr = '0;
    logic        unit_rst_n;
    logic        unit_cmd;
    logic [7:0]  unit_data;
    logic [7:0]  unit_addr;
    logic [7:0]  unit_dout;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_addr;
    logic [7:0]  rsp_data;
    logic        chk_err;
    logic        force_bad = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    incdec_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_cmd    (req_cmd),
        .i_req_data   (req_data),
        .i_req_addr   (req_addr),
        .o_unit_rst_n (unit_rst_n),
        .o_unit_cmd   (unit_cmd),
        .o_unit_data  (unit_data),
        .o_unit_addr  (unit_addr),
        .i_unit_dout  (unit_dout),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_addr   (rsp_addr),
        .o_rsp_data   (rsp_data),
        .o_chk_err    (chk_err)
    );

    // Registered inc/dec unit; force_bad makes it return 00.
    always @(posedge clk) begin
        if (!unit_rst_n)     unit_dout <= 8'h00;
        else if (force_bad)  unit_dout <= 8'h00;
        else if (unit_cmd)   unit_dout <= unit_data - 8'd1;
        else                 unit_dout <= unit_data + 8'd1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic cmd, input logic [7:0] d, input logic [7:0] a);
        req_cmd[idx]          = cmd;
        req_data[8*idx +: 8]  = d;
        req_addr[8*idx +: 8]  = a;
        req_valid[idx]        = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (unit_rst_n !== 1'b0) begin errors++; $display("FAIL rst_unit_rst_n got=%b exp=0", unit_rst_n); end
        checks++; if ({unit_cmd, unit_data, unit_addr} !== 17'h0) begin errors++; $display("FAIL rst_unit got=%h exp=0", {unit_cmd, unit_data, unit_addr}); end
        checks++; if ({rsp_id, rsp_addr, rsp_data} !== 18'h0) begin errors++; $display("FAIL rst_rsp got=%h exp=0", {rsp_id, rsp_addr, rsp_data}); end
        checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL rst_chk_err got=%b exp=0", chk_err); end
        rst = 1'b0;
        #1;
        checks++; if (unit_rst_n !== 1'b0) begin errors++; $display("FAIL unit_rst_hold got=%b exp=0", unit_rst_n); end
        tick();
        checks++; if (unit_rst_n !== 1'b1) begin errors++; $display("FAIL unit_rst_release got=%b exp=1", unit_rst_n); end
    endtask

    task automatic test_single();
        set_req(0, 1'b0, 8'h05, 8'h11);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL t1_ready got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t1_ready_issue got=%b exp=0000", req_ready); end
        checks++; if ({unit_cmd, unit_data, unit_addr} !== {1'b0, 8'h05, 8'h11}) begin errors++; $display("FAIL t1_unit got=%h exp=00511", {unit_cmd, unit_data, unit_addr}); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_early1 got=%b exp=0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_early2 got=%b exp=0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL t1_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if ({rsp_id, rsp_addr, rsp_data} !== {2'd0, 8'h11, 8'h06}) begin errors++; $display("FAIL t1_rsp got id=%0d addr=%h data=%h exp id=0 addr=11 data=06", rsp_id, rsp_addr, rsp_data); end
        checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL t1_chk_err got=%b exp=0", chk_err); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_rsp_clear got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_wrap();
        int         t_idx  [3] = '{1, 2, 3};
        logic       t_cmd  [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] t_data [3] = '{8'h00, 8'hFF, 8'h80};
        logic [7:0] t_addr [3] = '{8'h22, 8'h33, 8'h44};
        logic [7:0] t_exp  [3] = '{8'hFF, 8'h00, 8'h7F};
        for (int i = 0; i < 3; i++) begin
            set_req(t_idx[i], t_cmd[i], t_data[i], t_addr[i]);
            #1;
            checks++; if (req_ready !== 4'(1 << t_idx[i])) begin errors++; $display("FAIL t2_ready[%0d] got=%b exp=%b", i, req_ready, 4'(1 << t_idx[i])); end
            tick();
            req_valid = '0;
            tick();
            tick();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL t2_valid[%0d] got=%b exp=1", i, rsp_valid); end
            checks++; if ({rsp_id, rsp_addr, rsp_data} !== {2'(t_idx[i]), t_addr[i], t_exp[i]}) begin errors++; $display("FAIL t2_rsp[%0d] got id=%0d addr=%h data=%h exp id=%0d addr=%h data=%h", i, rsp_id, rsp_addr, rsp_data, t_idx[i], t_addr[i], t_exp[i]); end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(8'h10 * i + 3), 8'(i));
        tick();
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t3_unit_rst_wait got=%b exp=0000", req_ready); end
        tick();
        rsp_ready = 1'b1;
        for (int g = 0; g < 8; g++) begin
            checks++; if (req_ready !== 4'(1 << (g % 4))) begin errors++; $display("FAIL t3_grant[%0d] got=%b exp=%b", g, req_ready, 4'(1 << (g % 4))); end
            tick();
            tick();
            tick();
            checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(g % 4), 8'(8'h10 * (g % 4) + 4)}) begin errors++; $display("FAIL t3_rsp[%0d] got v=%b id=%0d data=%h exp v=1 id=%0d data=%h", g, rsp_valid, rsp_id, rsp_data, g % 4, 8'(8'h10 * (g % 4) + 4)); end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        set_req(3, 1'b0, 8'h7F, 8'hA5);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL t4_ready got=%b exp=1000", req_ready); end
        tick();
        req_valid = '0;
        set_req(0, 1'b1, 8'h10, 8'h01);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if ({rsp_valid, rsp_id, rsp_addr, rsp_data, req_ready} !== {1'b1, 2'd3, 8'hA5, 8'h80, 4'b0000}) begin errors++; $display("FAIL t4_hold[%0d] got v=%b id=%0d addr=%h data=%h rdy=%b exp v=1 id=3 addr=a5 data=80 rdy=0000", c, rsp_valid, rsp_id, rsp_addr, rsp_data, req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL t4_ready_resp got=%b exp=0000", req_ready); end
        tick();
        rsp_ready = 1'b0;
        #1;
        checks++; if ({rsp_valid, req_ready} !== {1'b0, 4'b0001}) begin errors++; $display("FAIL t4_next_grant got v=%b rdy=%b exp v=0 rdy=0001", rsp_valid, req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 8'h0F}) begin errors++; $display("FAIL t4_second got v=%b id=%0d data=%h exp v=1 id=0 data=0f", rsp_valid, rsp_id, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 1'b0, 8'h42, 8'h77);
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if ({rsp_valid, unit_rst_n, req_ready, unit_data, unit_addr} !== 22'h0) begin errors++; $display("FAIL t5_async got v=%b urst=%b rdy=%b udata=%h uaddr=%h exp all 0", rsp_valid, unit_rst_n, req_ready, unit_data, unit_addr); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) req_valid[i] = 1'b1;
        #1;
        checks++; if ({rsp_valid, req_ready} !== 5'b0) begin errors++; $display("FAIL t5_post_rst got v=%b rdy=%b exp v=0 rdy=0000", rsp_valid, req_ready); end
        tick();
        checks++; if ({rsp_valid, req_ready} !== {1'b0, 4'b0001}) begin errors++; $display("FAIL t5_grant got v=%b rdy=%b exp v=0 rdy=0001", rsp_valid, req_ready); end
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t5_no_rsp got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_checker();
        logic exp_err;
`ifdef INCDEC_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        force_bad = 1'b1;
        set_req(0, 1'b0, 8'h05, 8'h11);
        tick();
        req_valid = '0;
        tick();
        checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL t6_pre got=%b exp=0", chk_err); end
        tick();
        checks++; if ({chk_err, rsp_data} !== {exp_err, 8'h00}) begin errors++; $display("FAIL t6_flag got err=%b data=%h exp err=%b data=00", chk_err, rsp_data, exp_err); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        force_bad = 1'b0;
        tick();
        checks++; if (chk_err !== exp_err) begin errors++; $display("FAIL t6_sticky got=%b exp=%b", chk_err, exp_err); end
        rst = 1'b1;
        #1;
        checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL t6_clear got=%b exp=0", chk_err); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        @(negedge clk);
        #1;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_checker();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
